i2c_master_read_byte: RTL and testbench
=======================================

# i2c_master_read_byte

Bit-timed I2C master receive engine, the read-direction companion to the master write-byte engine. It sits under the byte-level controller and uses the same `go`/`command`/`finish` handshake. It clocks in one byte MSB-first from SDA and then drives the master ACK or NACK, or it samples a single slave ACK bit. It supports slave clock stretching.

## Interface
- `QUARTER`, default 4: system clocks per quarter SCL bit period; legal values 1..255.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  level request; a command is accepted only in IDLE.
- `command`  in  3  operation code, sampled on acceptance.
- `sda_in`  in  1  synchronized SDA line level.
- `scl_in`  in  1  synchronized SCL line level, used for stretch detection.
- `scl`  out  1  SCL drive; 1 = released/high.
- `sda_oe`  out  1  open-drain SDA pull-low enable.
- `data`  out  8  received byte; valid from the `finish` cycle until the next acceptance.
- `ack_received`  out  1  1 = slave ACKed (SDA low); valid with `finish` of CHECK_ACK.
- `busy`  out  1  high from the acceptance cycle through the `finish` cycle.
- `finish`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse with `finish` for an illegal command.

## Operation
- Command codes:
  - RECV_ACK = 3'b010: 8 data bits, then the master drives ACK.
  - RECV_NACK = 3'b011: 8 data bits, then SDA is released for NACK.
  - CHECK_ACK = 3'b111: one bit sampled into `ack_received`.
  - All other codes are illegal.
- States:
  - IDLE: waits for `go`=1.
  - LOW: `scl`=0 for 2·QUARTER cycles.
  - HIGH: `scl`=1 for 2·QUARTER counted cycles.
  - DONE: drives the `finish` pulse.
  - REARM: waits for `go`=0.
- Transitions:
  - IDLE→LOW on `go` with a legal command.
  - LOW→HIGH when the low count expires.
  - HIGH→LOW when the high count expires and bits remain; HIGH→DONE after the last bit.
  - DONE→REARM unconditionally.
  - REARM→IDLE when `go`=0.
  - An illegal command goes IDLE→DONE, with no SCL activity and `error`=1.
- Bit counter runs 0..8 for RECV_*, and 0 only for CHECK_ACK.
- Sampling: the shift register samples on the HIGH-phase cycle where the high count equals QUARTER-1.
  - Data bits shift as shift <= {shift[6:0], sda_in}.
  - `data` loads from shift at DONE.
  - For CHECK_ACK, `ack_received` <= ~sda_in.
- SDA drive:
  - `sda_oe`=0 during data bits and CHECK_ACK.
  - For RECV_ACK, `sda_oe`=1 from the first LOW cycle of bit 8 through the DONE cycle, and 0 in REARM.
  - For RECV_NACK, `sda_oe` stays 0 throughout.
- Clock stretching: in HIGH, while `scl`=1 and `scl_in`=0, the high counter holds. Sampling happens only on counted cycles.
- `command` and `go` changes are ignored outside IDLE/REARM.
- Reset values:
  - `scl`=1, `sda_oe`=0.
  - `data`=8'h00, `ack_received`=0.
  - `busy`=0, `finish`=0, `error`=0.
  - State = IDLE.
- After any completed RECV/CHECK operation, `scl` stays 0 (bus held low) until the next operation or reset.

## Timing
- Acceptance occurs in cycle n (IDLE, `go`=1); LOW starts at n+1.
- With no stretching, `finish` is at n+1+36·QUARTER for RECV_*, and at n+1+4·QUARTER for CHECK_ACK.
- The sample point is QUARTER cycles after SCL rises, mid-high.
- An illegal command gives `finish`=`error`=1 at n+1.
- Each stretched cycle adds exactly one cycle of latency.
- Re-arm: holding `go` high after `finish` never starts a second operation. The earliest re-acceptance is the first cycle `go`=1 after at least one REARM cycle with `go`=0.
- Reset mid-operation: all outputs take reset values at the next edge, including releasing SDA. There is no `finish` pulse and a partial byte is discarded.
- `go` and `reset` both high: reset wins.

## Structure
- Shared package `i2c_pkg`:
  - command code constants (shared with the write engine);
  - state enum;
  - `I2C_BITS_PER_BYTE`=8.
- Sub-module `i2c_bit_timer`: phase counter with QUARTER parameter, stretch hold input, and outputs `phase_done` and `sample_now`.
- Counter width is $clog2(2·QUARTER).

## Test plan
- QUARTER=2, RECV_ACK, slave drives 8'hA5 aligned to SCL low → `data`=8'hA5 at `finish`, n+73. `sda_oe`=1 exactly during bit 8 through DONE, and SDA is stable while SCL is high.
- RECV_NACK with slave 8'h3C → `data`=8'h3C and `sda_oe` never asserts.
- CHECK_ACK with `sda_in`=0 → `ack_received`=1 at n+9. Repeating with `sda_in`=1 → `ack_received`=0.
- Slave holds `scl_in` low for 5 cycles in bit 3 → `finish` is delayed by exactly 5 cycles and `data` is correct.
- Command 3'b001 → `finish`=`error`=1 at n+1, `scl` unchanged. `go` held high for 20 cycles after any `finish` → no second `busy`.
- Reset asserted at bit 4 of RECV_ACK → next cycle `scl`=1, `sda_oe`=0, `data`=8'h00, no `finish`. A new command after reset completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C engine definitions: command codes, engine states,
// byte geometry and small command-decode helpers.
package i2c_pkg;

  localparam int I2C_BITS_PER_BYTE = 8;

  localparam logic [2:0] I2C_CMD_RECV_ACK  = 3'b010;
  localparam logic [2:0] I2C_CMD_RECV_NACK = 3'b011;
  localparam logic [2:0] I2C_CMD_CHECK_ACK = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DONE,
    ST_REARM
  } i2c_state_t;

  function automatic logic i2c_cmd_legal(
    input logic [2:0] cmd
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (cmd == I2C_CMD_RECV_ACK):  ok = 1'b1;
      (cmd == I2C_CMD_RECV_NACK): ok = 1'b1;
      (cmd == I2C_CMD_CHECK_ACK): ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the final bit slot: 8 data bits plus
  // the ACK slot for receives, a single slot for CHECK_ACK.
  function automatic logic [3:0] i2c_last_bit(
    input logic [2:0] cmd
  );
    if (cmd == I2C_CMD_CHECK_ACK)
      return 4'd0;
    return 4'(I2C_BITS_PER_BYTE);
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// SCL phase timer: counts 2*QUARTER cycles per half bit.
// Ports: clock, reset, run, hold, high_phase -> phase_done, sample_now.
module i2c_bit_timer #(
  parameter int unsigned QUARTER = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic hold,
  input  logic high_phase,
  output logic phase_done,
  output logic sample_now
);

  localparam int unsigned CW = $clog2(2 * QUARTER);
  localparam logic [CW-1:0] LAST = CW'(2 * QUARTER - 1);
  localparam logic [CW-1:0] MID  = CW'(QUARTER - 1);

  logic [CW-1:0] cnt;
  logic          step;

  // A held cycle (stretch) neither advances nor samples.
  assign step       = run && !hold;
  assign phase_done = step && (cnt == LAST);
  assign sample_now = step && high_phase && (cnt == MID);

  always_ff @(posedge clock) begin
    if (reset || !run)
      cnt <= '0;
    else if (step)
      cnt <= phase_done ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/i2c_master_read_byte.sv
// I2C master receive engine: reads a byte MSB-first then ACK/NACK,
// or samples one slave ACK. Ports: clock, reset, go, command,
// sda_in, scl_in -> scl, sda_oe, data, ack_received, busy,
// finish, error.
module i2c_master_read_byte
  import i2c_pkg::*;
#(
  parameter int unsigned QUARTER = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] command,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       scl,
  output logic       sda_oe,
  output logic [7:0] data,
  output logic       ack_received,
  output logic       busy,
  output logic       finish,
  output logic       error
);

  i2c_state_t state;
  logic [2:0] cmd;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       busy_r;
  logic       accept;
  logic       run;
  logic       hold;
  logic       in_high;
  logic       phase_done;
  logic       sample_now;

  // busy covers the acceptance cycle itself, before the
  // registered flag can rise.
  assign accept  = (state == ST_IDLE) && go && !reset;
  assign busy    = busy_r || accept;

  assign in_high = (state == ST_HIGH);
  assign run     = (state == ST_LOW) || in_high;
  // Slave holds SCL low after we released it.
  assign hold    = in_high && scl && !scl_in;

  i2c_bit_timer #(
    .QUARTER (QUARTER)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .hold       (hold),
    .high_phase (in_high),
    .phase_done (phase_done),
    .sample_now (sample_now)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd          <= 3'b000;
      bit_cnt      <= 4'd0;
      shift        <= 8'h00;
      busy_r       <= 1'b0;
      scl          <= 1'b1;
      sda_oe       <= 1'b0;
      data         <= 8'h00;
      ack_received <= 1'b0;
      finish       <= 1'b0;
      error        <= 1'b0;
    end else begin
      finish <= 1'b0;
      error  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            busy_r  <= 1'b1;
            cmd     <= command;
            bit_cnt <= 4'd0;
            shift   <= 8'h00;
            if (i2c_cmd_legal(command)) begin
              state <= ST_LOW;
              scl   <= 1'b0;
            end else begin
              state  <= ST_DONE;
              finish <= 1'b1;
              error  <= 1'b1;
            end
          end
        end

        ST_LOW: begin
          if (phase_done) begin
            state <= ST_HIGH;
            scl   <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (sample_now) begin
            if (cmd == I2C_CMD_CHECK_ACK)
              ack_received <= ~sda_in;
            else if (bit_cnt < 4'(I2C_BITS_PER_BYTE))
              shift <= {shift[6:0], sda_in};
          end
          if (phase_done) begin
            // Bus is left held low between operations.
            scl <= 1'b0;
            if (bit_cnt == i2c_last_bit(cmd)) begin
              state  <= ST_DONE;
              finish <= 1'b1;
              if (cmd != I2C_CMD_CHECK_ACK)
                data <= shift;
            end else begin
              state   <= ST_LOW;
              bit_cnt <= bit_cnt + 4'd1;
              // Drive ACK from the first low cycle of the ACK slot.
              if ((cmd == I2C_CMD_RECV_ACK) &&
                  (bit_cnt == 4'(I2C_BITS_PER_BYTE - 1)))
                sda_oe <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state  <= ST_REARM;
          busy_r <= 1'b0;
          sda_oe <= 1'b0;
        end

        ST_REARM: begin
          if (!go)
            state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Randomized bench for i2c_master_read_byte against a
// transaction-level slave/timing model.
module tb_i2c_master_read_byte;

  localparam int Q = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       go;
  logic [2:0] command;
  logic       sda_in;
  logic       scl_in;
  logic       scl;
  logic       sda_oe;
  logic [7:0] data;
  logic       ack_received;
  logic       busy;
  logic       finish;
  logic       error;

  int checks = 0;
  int errors = 0;

  i2c_master_read_byte #(
    .QUARTER (Q)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .go           (go),
    .command      (command),
    .sda_in       (sda_in),
    .scl_in       (scl_in),
    .scl          (scl),
    .sda_oe       (sda_oe),
    .data         (data),
    .ack_received (ack_received),
    .busy         (busy),
    .finish       (finish),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transaction. st_bit: bit slot to stretch (-1 none).
  // rst_bit: reset during the high phase of that slot (-1 none).
  task automatic run_op(input logic [2:0] c,
                        input logic [7:0] b,
                        input logic ackbit,
                        input int st_bit,
                        input int st_len,
                        input int rst_bit);
    bit   legal, is_chk, is_ack, done;
    int   nbits, exp_k, k, falls, rises, left;
    int   oe_bad, busy_bad, oe_move, rb, rs;
    logic scl_before, scl_after, prev_scl, prev_oe, exp_oe;

    legal  = (c == 3'b010) || (c == 3'b011) || (c == 3'b111);
    is_chk = (c == 3'b111);
    is_ack = (c == 3'b010);
    nbits  = !legal ? 0 : (is_chk ? 1 : 9);
    exp_k  = 4 * Q * nbits;
    if (st_bit >= 0 && st_bit < nbits)
      exp_k += st_len;
    scl_before = scl;
    scl_after  = legal ? 1'b0 : scl_before;
    done = 0; k = 0; falls = 0; rises = 0; left = 0;
    oe_bad = 0; busy_bad = 0; oe_move = 0; rb = 0; rs = 0;

    sda_in  = is_chk ? ackbit : b[7];
    scl_in  = 1'b1;
    command = c;
    go      = 1'b1;
    #1;
    chk("busy_at_accept", busy, 1);
    tick();
    prev_scl = scl;
    prev_oe  = sda_oe;

    while (!done && k <= exp_k + 40) begin
      if (!prev_scl && scl) rises++;
      if (prev_scl && !scl) begin
        falls++;
        if (!is_chk)
          sda_in = (falls < 8) ? b[7 - falls] : 1'b1;
      end
      if (rst_bit >= 0 && falls == rst_bit && scl) begin
        reset = 1'b1;
        go    = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_scl", scl, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_data", data, 8'h00);
        chk("rst_busy", busy, 0);
        rb = 0;
        for (int i = 0; i < 12; i++) begin
          if (finish) rb++;
          tick();
        end
        chk("rst_no_finish", rb, 0);
        return;
      end
      if (!busy) busy_bad++;
      exp_oe = is_ack && (falls >= 8);
      if (sda_oe !== exp_oe) oe_bad++;
      if (scl && sda_oe !== prev_oe) oe_move++;
      if (finish) begin
        done = 1;
        chk("finish_cycle", k, exp_k);
        chk("error_flag", error, !legal);
        if (legal && !is_chk) chk("data", data, b);
        if (is_chk) chk("ack_received", ack_received, !ackbit);
      end else begin
        if (!prev_scl && scl && rises - 1 == st_bit)
          left = st_len;
        if (left > 0) begin
          scl_in = 1'b0;
          left--;
        end else begin
          scl_in = 1'b1;
        end
        prev_scl = scl;
        prev_oe  = sda_oe;
        tick();
        k++;
      end
    end
    scl_in = 1'b1;
    chk("finish_seen", done, 1);
    chk("busy_during_op", busy_bad, 0);
    chk("sda_oe_window", oe_bad, 0);
    chk("sda_stable_scl_high", oe_move, 0);
    chk("scl_pulses", rises, nbits);

    rb = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || finish || sda_oe) rb++;
      if (scl !== scl_after) rs++;
    end
    chk("rearm_quiet", rb, 0);
    chk("scl_after_op", rs, 0);
    go = 1'b0;
    tick();
    tick();
    if (legal && !is_chk) chk("data_kept", data, b);
  endtask

  initial begin
    logic [2:0] rc;
    logic [7:0] rbyte;
    int         sb, nb;

    reset   = 1'b1;
    go      = 1'b0;
    command = 3'b000;
    sda_in  = 1'b1;
    scl_in  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_scl", scl, 1);
    chk("reset_sda_oe", sda_oe, 0);
    chk("reset_data", data, 8'h00);
    chk("reset_ack", ack_received, 0);
    chk("reset_busy", busy, 0);
    chk("reset_finish", finish, 0);
    chk("reset_error", error, 0);
    tick();

    run_op(3'b010, 8'hA5, 1'b1, -1, 0, -1);
    run_op(3'b011, 8'h3C, 1'b1, -1, 0, -1);
    run_op(3'b111, 8'h00, 1'b0, -1, 0, -1);
    run_op(3'b111, 8'h00, 1'b1, -1, 0, -1);
    run_op(3'b010, 8'h96, 1'b1, 3, 5, -1);
    run_op(3'b001, 8'h00, 1'b1, -1, 0, -1);
    run_op(3'b010, 8'hC3, 1'b1, -1, 0, 4);
    run_op(3'b000, 8'h00, 1'b1, -1, 0, -1);
    run_op(3'b010, 8'h5A, 1'b1, -1, 0, 8);
    run_op(3'b011, 8'h81, 1'b1, -1, 0, -1);

    for (int n = 0; n < 10; n++) begin
      rc    = 3'($urandom_range(0, 7));
      rbyte = 8'($urandom);
      nb    = (rc == 3'b111) ? 1 : 9;
      sb    = ($urandom_range(0, 1) == 1) ?
              int'($urandom_range(0, nb - 1)) : -1;
      run_op(rc, rbyte, 1'($urandom), sb,
             int'($urandom_range(1, 6)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
